// File: rtl/emg_preempt_pkg.sv
// Shared encodings for the emergency-preemption requester.
// Optional feature macro used by the top: EMG_FAIR_ARB_EN.
package emg_preempt_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    SERVED   = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

endpackage

// File: rtl/emergency_preempt_requester_if.sv
// Emergency request / green read-back link between requester (master)
// and traffic light controller (slave).
interface emergency_preempt_requester_if;
  logic emg_ns;
  logic emg_ew;
  logic ns_green;
  logic ew_green;

  modport master (output emg_ns, output emg_ew, input ns_green, input ew_green);
  modport slave  (input emg_ns, input emg_ew, output ns_green, output ew_green);
endinterface

// File: rtl/emergency_preempt_requester_debounce.sv
// emg_debounce: 2-flop synchronizer, stability counter and a one-cycle
// pulse on the cycle the debounced level rises.
module emg_debounce #(
  parameter int COUNTER_WIDTH  = 32,
  parameter int DEBOUNCE_TICKS = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] CNT_LAST = COUNTER_WIDTH'(DEBOUNCE_TICKS - 1);

  logic                     sync1_q;
  logic                     sync2_q;
  logic                     level_q;
  logic                     level_d;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= CNT_ZERO;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter only runs while the synchronized input disagrees with the
  // debounced level, so it stops at CNT_LAST and never wraps.
  always_comb begin
    level_d = level_q;
    cnt_d   = CNT_ZERO;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        cnt_d   = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  assign rise_o = level_d & ~level_q;

endmodule

// File: rtl/emergency_preempt_requester.sv
// Emergency preemption requester: debounces two buttons, issues one
// request at a time, waits for lamp confirmation, then cools down.
// Optional feature: EMG_FAIR_ARB_EN (alternating tie priority).
module emergency_preempt_requester
  import emg_preempt_pkg::*;
#(
  parameter int COUNTER_WIDTH  = 32,
  parameter int DEBOUNCE_TICKS = 500000,
  parameter int MAX_HOLD_TICKS = 200000000,
  parameter int COOLDOWN_TICKS = 100000000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  btn_ns,
  input  logic                                  btn_ew,
  emergency_preempt_requester_if.master         bus,
  output logic                                  busy,
  output logic                                  timeout_err,
  output logic [1:0]                            state_debug
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ZERO  = {COUNTER_WIDTH{1'b0}};
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE   = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST = COUNTER_WIDTH'(MAX_HOLD_TICKS - 1);
  localparam logic [COUNTER_WIDTH-1:0] COOL_LAST = COUNTER_WIDTH'(COOLDOWN_TICKS - 1);

  state_e                   state_q, state_d;
  dir_e                     dir_q, dir_d;
  logic [COUNTER_WIDTH-1:0] hold_q, hold_d;
  logic                     pend_ns_q, pend_ns_d;
  logic                     pend_ew_q, pend_ew_d;
  logic                     emg_ns_q, emg_ns_d;
  logic                     emg_ew_q, emg_ew_d;
  logic                     busy_q, busy_d;
  logic                     terr_q, terr_d;
  logic                     rise_ns, rise_ew;
  logic                     clr_ns, clr_ew;
  logic                     green_sel;
`ifdef EMG_FAIR_ARB_EN
  dir_e                     last_dir_q, last_dir_d;
`endif

  emg_debounce #(.COUNTER_WIDTH(COUNTER_WIDTH), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_ns (
    .clk(clk), .rst(rst), .btn_i(btn_ns), .rise_o(rise_ns)
  );
  emg_debounce #(.COUNTER_WIDTH(COUNTER_WIDTH), .DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_ew (
    .clk(clk), .rst(rst), .btn_i(btn_ew), .rise_o(rise_ew)
  );

  assign green_sel = (dir_q == DIR_NS) ? bus.ns_green : bus.ew_green;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_q     <= DIR_NS;
      hold_q    <= CNT_ZERO;
      pend_ns_q <= 1'b0;
      pend_ew_q <= 1'b0;
      emg_ns_q  <= 1'b0;
      emg_ew_q  <= 1'b0;
      busy_q    <= 1'b0;
      terr_q    <= 1'b0;
`ifdef EMG_FAIR_ARB_EN
      last_dir_q <= DIR_EW;
`endif
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      hold_q    <= hold_d;
      pend_ns_q <= pend_ns_d;
      pend_ew_q <= pend_ew_d;
      emg_ns_q  <= emg_ns_d;
      emg_ew_q  <= emg_ew_d;
      busy_q    <= busy_d;
      terr_q    <= terr_d;
`ifdef EMG_FAIR_ARB_EN
      last_dir_q <= last_dir_d;
`endif
    end
  end

  // hold_q is shared: acknowledge window in REQ, cooldown timer in COOLDOWN.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    terr_d  = terr_q;
    clr_ns  = 1'b0;
    clr_ew  = 1'b0;
`ifdef EMG_FAIR_ARB_EN
    last_dir_d = last_dir_q;
`endif
    case (state_q)
      IDLE: begin
        hold_d = CNT_ZERO;
        if (pend_ns_q && pend_ew_q) begin
`ifdef EMG_FAIR_ARB_EN
          dir_d = (last_dir_q == DIR_NS) ? DIR_EW : DIR_NS;
`else
          dir_d = DIR_NS;
`endif
          state_d = REQ;
        end else if (pend_ns_q) begin
          dir_d   = DIR_NS;
          state_d = REQ;
        end else if (pend_ew_q) begin
          dir_d   = DIR_EW;
          state_d = REQ;
        end else begin
          state_d = IDLE;
        end
`ifdef EMG_FAIR_ARB_EN
        if (state_d == REQ) begin
          last_dir_d = dir_d;
        end else begin
          last_dir_d = last_dir_q;
        end
`endif
      end
      REQ: begin
        if (green_sel && (hold_q != CNT_ZERO)) begin
          clr_ns  = (dir_q == DIR_NS);
          clr_ew  = (dir_q == DIR_EW);
          hold_d  = CNT_ZERO;
          state_d = SERVED;
        end else if (hold_q == HOLD_LAST) begin
          clr_ns  = (dir_q == DIR_NS);
          clr_ew  = (dir_q == DIR_EW);
          terr_d  = 1'b1;
          hold_d  = CNT_ZERO;
          state_d = COOLDOWN;
        end else begin
          hold_d = hold_q + CNT_ONE;
        end
      end
      SERVED: begin
        hold_d = CNT_ZERO;
        if (!green_sel) begin
          state_d = COOLDOWN;
        end else begin
          state_d = SERVED;
        end
      end
      COOLDOWN: begin
        if (hold_q == COOL_LAST) begin
          hold_d  = CNT_ZERO;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + CNT_ONE;
        end
      end
      default: begin
        hold_d  = CNT_ZERO;
        state_d = IDLE;
      end
    endcase
  end

  // A press while already pending is absorbed; service clears it.
  always_comb begin
    pend_ns_d = (pend_ns_q | rise_ns) & ~clr_ns;
    pend_ew_d = (pend_ew_q | rise_ew) & ~clr_ew;
  end

  always_comb begin
    emg_ns_d = (state_d == REQ) && (dir_d == DIR_NS);
    emg_ew_d = (state_d == REQ) && (dir_d == DIR_EW);
    busy_d   = (state_d != IDLE);
  end

  assign bus.emg_ns  = emg_ns_q;
  assign bus.emg_ew  = emg_ew_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;
  assign state_debug = state_q;

endmodule

// File: tb/tb_emergency_preempt_requester.sv
// Directed bench for emergency_preempt_requester with short tick counts
// (debounce 4, max hold 20, cooldown 10).
module tb_emergency_preempt_requester;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ns, btn_ew;
  logic       busy, timeout_err;
  logic [1:0] state_debug;
  int         checks = 0;
  int         errors = 0;

  emergency_preempt_requester_if bus ();

  emergency_preempt_requester #(
    .COUNTER_WIDTH(32), .DEBOUNCE_TICKS(4), .MAX_HOLD_TICKS(20), .COOLDOWN_TICKS(10)
  ) dut (
    .clk(clk), .rst(rst), .btn_ns(btn_ns), .btn_ew(btn_ew), .bus(bus),
    .busy(busy), .timeout_err(timeout_err), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       b_ns;
    logic       b_ew;
    logic       g_ns;
    logic       g_ew;
    int         ncyc;
    logic [4:0] exp;   // {emg_ns, emg_ew, busy, state_debug}
  } vec_t;

  vec_t vecs[$];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs();
    return {bus.emg_ns, bus.emg_ew, busy, state_debug};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_ns, first_ew, high_cnt, st_at_fall, terr_at_fall;
    logic both, prev;

    rst = 1'b1; btn_ns = 1'b0; btn_ew = 1'b0;
    bus.ns_green = 1'b0; bus.ew_green = 1'b0;
    tick(3);
    rst = 1'b0;
    chk("reset_outputs", {27'd0, outs()}, 32'd0);
    chk("reset_timeout", {31'd0, timeout_err}, 32'd0);

    // Single NS request with lamp echo, then bounce on EW
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 6, 5'b00_0_00});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1, 5'b10_1_01});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 2, 5'b10_1_01});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1, 5'b00_1_10});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 7, 5'b00_1_10});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 5'b00_1_11});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 9, 5'b00_1_11});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1, 5'b00_0_00});
    for (int k = 0; k < 5; k++) begin
      vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 2, 5'b00_0_00});
      vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 2, 5'b00_0_00});
    end
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 10, 5'b00_0_00});

    foreach (vecs[i]) begin
      btn_ns = vecs[i].b_ns; btn_ew = vecs[i].b_ew;
      bus.ns_green = vecs[i].g_ns; bus.ew_green = vecs[i].g_ew;
      tick(vecs[i].ncyc);
      chk($sformatf("vec%0d", i), {27'd0, outs()}, {27'd0, vecs[i].exp});
    end

    // Simultaneous press, greens echo the requests
    first_ns = -1; first_ew = -1; both = 1'b0;
    btn_ns = 1'b1; btn_ew = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 8) begin btn_ns = 1'b0; btn_ew = 1'b0; end
      if (bus.emg_ns && first_ns < 0) first_ns = i;
      if (bus.emg_ew && first_ew < 0) first_ew = i;
      if (bus.emg_ns && bus.emg_ew) both = 1'b1;
      bus.ns_green = bus.emg_ns;
      bus.ew_green = bus.emg_ew;
    end
`ifdef EMG_FAIR_ARB_EN
    chk("tie_first_ew", first_ew, 7);
    chk("tie_then_ns", first_ns, 21);
`else
    chk("tie_first_ns", first_ns, 7);
    chk("tie_then_ew", first_ew, 21);
`endif
    chk("tie_never_both", {31'd0, both}, 32'd0);
    chk("tie_end_idle", {27'd0, outs()}, 32'd0);

    // Green already high when the request appears
    first_ns = -1; high_cnt = 0;
    btn_ns = 1'b1; bus.ns_green = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 8) btn_ns = 1'b0;
      if (bus.emg_ns) high_cnt++;
      if (bus.emg_ns && first_ns < 0) first_ns = i;
    end
    chk("pregreen_rise", first_ns, 7);
    chk("pregreen_width", high_cnt, 2);
    chk("pregreen_served", {30'd0, state_debug}, 32'd2);
    bus.ns_green = 1'b0;
    tick(12);
    chk("pregreen_idle", {27'd0, outs()}, 32'd0);

    // No acknowledge: timeout
    high_cnt = 0; st_at_fall = -1; terr_at_fall = -1; prev = 1'b0;
    btn_ns = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 8) btn_ns = 1'b0;
      if (bus.emg_ns) high_cnt++;
      if (prev && !bus.emg_ns) begin
        st_at_fall = int'(state_debug);
        terr_at_fall = int'(timeout_err);
      end
      prev = bus.emg_ns;
    end
    chk("timeout_width", high_cnt, 20);
    chk("timeout_state", st_at_fall, 3);
    chk("timeout_flag", terr_at_fall, 1);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
    chk("timeout_idle", {27'd0, outs()}, 32'd0);

    // Reset while an EW request is active
    btn_ew = 1'b1;
    tick(7);
    chk("rst_pre_req", {27'd0, outs()}, {27'd0, 5'b01_1_01});
    btn_ew = 1'b0; rst = 1'b1;
    tick(1);
    chk("rst_mid_req", {26'd0, timeout_err, outs()}, 32'd0);
    rst = 1'b0;
    tick(30);
    chk("rst_pend_lost", {26'd0, timeout_err, outs()}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
